// File: rtl/conv_mem_responder_if.sv
// CONV-side memory interface of conv_mem_responder.
// master: the CONV accelerator (drives busy, image read address, layer accesses).
// slave : the responder (drives ready, idata, cdata_rd).
interface conv_mem_responder_if #(
    parameter int unsigned DW  = 20,
    parameter int unsigned IAW = 12
);
    logic           ready;
    logic           busy;
    logic [IAW-1:0] iaddr;
    logic [DW-1:0]  idata;
    logic           cwr;
    logic [IAW-1:0] caddr_wr;
    logic [DW-1:0]  cdata_wr;
    logic           crd;
    logic [IAW-1:0] caddr_rd;
    logic [DW-1:0]  cdata_rd;
    logic [2:0]     csel;

    modport master (
        output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
        input  ready, idata, cdata_rd
    );

    modport slave (
        input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
        output ready, idata, cdata_rd
    );
endinterface

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the CONV accelerator.
// Holds the input image, the L0 (conv) and L1 (max-pool) layer banks, runs the
// ready/busy start handshake and offers a host readback port once CONV is done.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   ld_en/ld_addr/ld_data host image load (IDLE and DONE only)
//   start                 host launch request
//   conv                  CONV-side interface (slave modport)
//   rb_en/rb_sel/rb_addr  host readback request, rb_data one cycle later
//   done                  one-cycle pulse when busy falls
//   hs_err, csel_err      sticky error flags, cleared by start
//   wr0_cnt, wr1_cnt      saturating accepted-write counters per bank
module conv_mem_responder #(
    parameter int unsigned DW         = 20,
    parameter int unsigned IAW        = 12,
    parameter int unsigned L1AW       = 10,
    parameter int unsigned HS_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ld_en,
    input  logic [IAW-1:0]          ld_addr,
    input  logic [DW-1:0]           ld_data,
    input  logic                    start,
    conv_mem_responder_if.slave     conv,
    input  logic                    rb_en,
    input  logic                    rb_sel,
    input  logic [IAW-1:0]          rb_addr,
    output logic [DW-1:0]           rb_data,
    output logic                    done,
    output logic                    hs_err,
    output logic                    csel_err,
    output logic [IAW:0]            wr0_cnt,
    output logic [L1AW:0]           wr1_cnt
);
    localparam int unsigned L0_WORDS = 1 << IAW;
    localparam int unsigned L1_WORDS = 1 << L1AW;
    localparam int unsigned C0W      = IAW + 1;
    localparam int unsigned C1W      = L1AW + 1;
    localparam int unsigned HCW      = $clog2(HS_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_HSK, S_RUN, S_DONE} state_t;

    state_t state, state_nxt;

    logic [DW-1:0]  img_mem [L0_WORDS];
    logic [DW-1:0]  l0_mem  [L0_WORDS];
    logic [DW-1:0]  l1_mem  [L1_WORDS];

    logic [HCW-1:0] hs_cnt;
    logic           ready_q;
    logic [DW-1:0]  cdata_rd_q;

    logic hs_expire_c, host_phase_c, launch_c, img_we_c;
    logic l0_we_c, l1_we_c, rd0_c, rd1_c, csel_bad_c, rb_ok_c;
    logic ready_nxt_c, done_nxt_c;

    assign hs_expire_c = (hs_cnt == HCW'(HS_TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_HSK;
            S_HSK: begin
                if (conv.busy)       state_nxt = S_RUN;
                else if (hs_expire_c) state_nxt = S_IDLE;
            end
            S_RUN:  if (!conv.busy) state_nxt = S_DONE;
            S_DONE: if (start) state_nxt = S_HSK;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath control decode
    always_comb begin
        logic run, legal0, legal1, l1_upper_zero;
        run           = (state == S_RUN);
        legal0        = (conv.csel == 3'b001);
        legal1        = (conv.csel == 3'b011);
        l1_upper_zero = (conv.caddr_wr[IAW-1:L1AW] == '0);

        host_phase_c = (state == S_IDLE) || (state == S_DONE);
        launch_c     = host_phase_c && start;
        img_we_c     = host_phase_c && ld_en;
        rb_ok_c      = host_phase_c && rb_en;
        l0_we_c      = run && conv.cwr && legal0;
        l1_we_c      = run && conv.cwr && legal1 && l1_upper_zero;
        rd0_c        = run && conv.crd && legal0;
        rd1_c        = run && conv.crd && legal1;
        // Illegal bank select, or an L1 write whose address overflows the bank
        csel_bad_c   = run && (((conv.cwr || conv.crd) && !legal0 && !legal1) ||
                               (conv.cwr && legal1 && !l1_upper_zero));
        ready_nxt_c  = (state_nxt == S_HSK);
        done_nxt_c   = run && !conv.busy;
    end

    // Memory arrays: contents survive reset
    always_ff @(posedge clk) begin
        if (img_we_c) img_mem[ld_addr] <= ld_data;
        if (l0_we_c)  l0_mem[conv.caddr_wr] <= conv.cdata_wr;
        if (l1_we_c)  l1_mem[conv.caddr_wr[L1AW-1:0]] <= conv.cdata_wr;
    end

    // Registered outputs, handshake timer, flags and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_cnt     <= '0;
            ready_q    <= 1'b0;
            done       <= 1'b0;
            cdata_rd_q <= '0;
            rb_data    <= '0;
            hs_err     <= 1'b0;
            csel_err   <= 1'b0;
            wr0_cnt    <= '0;
            wr1_cnt    <= '0;
        end else begin
            ready_q <= ready_nxt_c;
            done    <= done_nxt_c;
            hs_cnt  <= (state == S_HSK) ? hs_cnt + HCW'(1) : '0;

            // Read-before-write: a same-cycle write lands after this sample
            if (rd0_c)      cdata_rd_q <= l0_mem[conv.caddr_rd];
            else if (rd1_c) cdata_rd_q <= l1_mem[conv.caddr_rd[L1AW-1:0]];

            if (rb_ok_c) rb_data <= rb_sel ? l1_mem[rb_addr[L1AW-1:0]] : l0_mem[rb_addr];

            if (launch_c) begin
                hs_err   <= 1'b0;
                csel_err <= 1'b0;
                wr0_cnt  <= '0;
                wr1_cnt  <= '0;
            end else begin
                if (state == S_HSK && !conv.busy && hs_expire_c) hs_err <= 1'b1;
                if (csel_bad_c) csel_err <= 1'b1;
                if (l0_we_c && wr0_cnt != C0W'(L0_WORDS)) wr0_cnt <= wr0_cnt + C0W'(1);
                if (l1_we_c && wr1_cnt != C1W'(L1_WORDS)) wr1_cnt <= wr1_cnt + C1W'(1);
            end
        end
    end

    // Image read is combinational and only visible while CONV runs
    assign conv.idata    = (state == S_RUN) ? img_mem[conv.iaddr] : '0;
    assign conv.ready    = ready_q;
    assign conv.cdata_rd = cdata_rd_q;

endmodule

// File: tb/tb_conv_mem_responder.sv
// Self-checking bench for conv_mem_responder: directed vector table, hand-written
// handshake/readback/reset sequences and a randomized run against a bank model.
module tb_conv_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        ld_en, start, rb_en, rb_sel;
    logic [11:0] ld_addr, rb_addr;
    logic [19:0] ld_data, rb_data;
    logic        done, hs_err, csel_err;
    logic [12:0] wr0_cnt;
    logic [10:0] wr1_cnt;

    int n_checks = 0;
    int n_errors = 0;

    conv_mem_responder_if #(.DW(20), .IAW(12)) cif ();

    conv_mem_responder #(.DW(20), .IAW(12), .L1AW(10), .HS_TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .conv(cif),
        .rb_en(rb_en), .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data),
        .done(done), .hs_err(hs_err), .csel_err(csel_err),
        .wr0_cnt(wr0_cnt), .wr1_cnt(wr1_cnt)
    );

    always #5 clk = ~clk;

    // Reference model of the memories and host-visible status
    logic [19:0] img_m [4096];
    logic [19:0] l0_m  [4096];
    logic [19:0] l1_m  [1024];
    int          cnt0, cnt1;
    logic [19:0] exp_rd, exp_rb;
    logic        exp_err;

    typedef struct {
        logic        cwr;
        logic        crd;
        logic [2:0]  csel;
        logic [11:0] aw;
        logic [19:0] dw;
        logic [11:0] ar;
        logic [19:0] exp_rd;
        logic        exp_err;
        int          exp_c0;
        int          exp_c1;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic w, input logic r, input logic [2:0] cs,
                           input logic [11:0] aw, input logic [19:0] dw, input logic [11:0] ar,
                           input logic [19:0] erd, input logic eerr, input int c0, input int c1);
        vec_t v;
        v.cwr = w; v.crd = r; v.csel = cs; v.aw = aw; v.dw = dw; v.ar = ar;
        v.exp_rd = erd; v.exp_err = eerr; v.exp_c0 = c0; v.exp_c1 = c1;
        vecs.push_back(v);
    endtask

    task automatic drive_conv(input logic w, input logic r, input logic [2:0] cs,
                              input logic [11:0] aw, input logic [19:0] dw, input logic [11:0] ar);
        cif.cwr = w; cif.crd = r; cif.csel = cs;
        cif.caddr_wr = aw; cif.cdata_wr = dw; cif.caddr_rd = ar;
        tick();
        cif.cwr = 1'b0; cif.crd = 1'b0;
    endtask

    // One CONV-side layer access, predicted from the bank rules
    task automatic op(input logic w, input logic r, input logic [2:0] cs,
                      input logic [11:0] aw, input logic [19:0] dw, input logic [11:0] ar,
                      input bit chk);
        bit l0, l1;
        l0 = (cs == 3'b001);
        l1 = (cs == 3'b011);
        if (r && l0) exp_rd = l0_m[ar];
        else if (r && l1) exp_rd = l1_m[ar[9:0]];
        if ((w || r) && !l0 && !l1) exp_err = 1'b1;
        if (w && l0) begin
            l0_m[aw] = dw;
            if (cnt0 < 4096) cnt0++;
        end
        if (w && l1) begin
            if (aw[11:10] != 2'b00) exp_err = 1'b1;
            else begin
                l1_m[aw[9:0]] = dw;
                if (cnt1 < 1024) cnt1++;
            end
        end
        drive_conv(w, r, cs, aw, dw, ar);
        if (chk) begin
            check("rnd_cdata_rd", 32'(cif.cdata_rd), 32'(exp_rd));
            check("rnd_csel_err", 32'(csel_err), 32'(exp_err));
            check("rnd_wr0_cnt", 32'(wr0_cnt), 32'(cnt0));
            check("rnd_wr1_cnt", 32'(wr1_cnt), 32'(cnt1));
        end
    endtask

    initial begin
        int n;
        int early_drop;
        reset = 1'b0;
        ld_en = 0; ld_addr = '0; ld_data = '0; start = 0;
        rb_en = 0; rb_sel = 0; rb_addr = '0;
        cif.busy = 0; cif.iaddr = '0; cif.cwr = 0; cif.crd = 0; cif.csel = '0;
        cif.caddr_wr = '0; cif.cdata_wr = '0; cif.caddr_rd = '0;
        exp_rb = '0;
        tick(); tick();

        // Reset state
        check("rst_ready", 32'(cif.ready), 0);
        check("rst_idata", 32'(cif.idata), 0);
        check("rst_cdata_rd", 32'(cif.cdata_rd), 0);
        check("rst_rb_data", 32'(rb_data), 0);
        check("rst_done", 32'(done), 0);
        check("rst_errs", {30'd0, hs_err, csel_err}, 0);
        check("rst_cnts", {8'd0, wr0_cnt, wr1_cnt}, 0);
        reset = 1'b1;
        tick();

        // Image load; the last word shares its cycle with start
        for (int k = 0; k < 4096; k++) begin
            img_m[k] = 20'(k);
            ld_en = 1; ld_addr = 12'(k); ld_data = 20'(k);
            if (k == 4095) start = 1;
            tick();
        end
        ld_en = 0; start = 0;
        check("hsk_ready", 32'(cif.ready), 1);
        tick(); tick();
        check("hsk_ready_hold", 32'(cif.ready), 1);
        cif.busy = 1;
        tick();
        check("run_ready_low", 32'(cif.ready), 0);
        cif.iaddr = 12'h123; #1;
        check("idata_123", 32'(cif.idata), 32'h00123);
        cif.iaddr = 12'hFFF; #1;
        check("idata_fff_start_load", 32'(cif.idata), 32'h00FFF);

        // Directed layer-access table
        add_vec(1, 0, 3'b001, 12'hFFF, 20'hABCDE, 12'h000, 20'h00000, 0, 1, 0);
        add_vec(0, 1, 3'b001, 12'h000, 20'h00000, 12'hFFF, 20'hABCDE, 0, 1, 0);
        add_vec(1, 0, 3'b011, 12'h3FF, 20'h11111, 12'h000, 20'hABCDE, 0, 1, 1);
        add_vec(1, 1, 3'b011, 12'h3FF, 20'h22222, 12'h3FF, 20'h11111, 0, 1, 2);
        add_vec(0, 1, 3'b011, 12'h000, 20'h00000, 12'h3FF, 20'h22222, 0, 1, 2);
        add_vec(1, 0, 3'b011, 12'h000, 20'h44444, 12'h000, 20'h22222, 0, 1, 3);
        add_vec(1, 0, 3'b010, 12'hFFF, 20'h55555, 12'h000, 20'h22222, 1, 1, 3);
        add_vec(0, 1, 3'b001, 12'h000, 20'h00000, 12'hFFF, 20'hABCDE, 1, 1, 3);
        add_vec(1, 0, 3'b011, 12'h400, 20'h33333, 12'h000, 20'hABCDE, 1, 1, 3);
        add_vec(0, 1, 3'b011, 12'h000, 20'h00000, 12'h000, 20'h44444, 1, 1, 3);
        add_vec(0, 1, 3'b111, 12'h000, 20'h00000, 12'hFFF, 20'h44444, 1, 1, 3);
        add_vec(0, 1, 3'b000, 12'h000, 20'h00000, 12'h3FF, 20'h44444, 1, 1, 3);
        foreach (vecs[i]) begin
            drive_conv(vecs[i].cwr, vecs[i].crd, vecs[i].csel, vecs[i].aw, vecs[i].dw, vecs[i].ar);
            check($sformatf("vec%0d_cdata_rd", i), 32'(cif.cdata_rd), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_csel_err", i), 32'(csel_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_wr0_cnt", i), 32'(wr0_cnt), 32'(vecs[i].exp_c0));
            check($sformatf("vec%0d_wr1_cnt", i), 32'(wr1_cnt), 32'(vecs[i].exp_c1));
        end

        // Bring the model in line with the table's effects
        l0_m[12'hFFF] = 20'hABCDE;
        l1_m[10'h3FF] = 20'h22222;
        l1_m[10'h000] = 20'h44444;
        cnt0 = 1; cnt1 = 3; exp_rd = 20'h44444; exp_err = 1'b1;

        // Random phase: fill a small window, then mixed traffic
        for (int a = 0; a < 32; a++) begin
            op(1, 0, 3'b001, 12'(a), 20'($urandom), 12'h0, 0);
            op(1, 0, 3'b011, 12'(a), 20'($urandom), 12'h0, 0);
        end
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [2:0] cs;
            r = $urandom_range(0, 9);
            if (r < 4) cs = 3'b001;
            else if (r < 8) cs = 3'b011;
            else if (r == 8) cs = 3'b010;
            else cs = 3'($urandom_range(4, 7));
            cif.iaddr = 12'($urandom);
            #1;
            check("rnd_idata", 32'(cif.idata), 32'(img_m[cif.iaddr]));
            rb_en = 1'($urandom); rb_sel = 1'($urandom); rb_addr = 12'($urandom);
            op(1'($urandom), 1'($urandom), cs, 12'($urandom_range(0, 31)),
               20'($urandom), 12'($urandom_range(0, 31)), 1);
            check("rnd_rb_hold", 32'(rb_data), 32'(exp_rb));
        end
        rb_en = 0;

        // Counter saturation on both banks
        for (int i = 0; i < 4098; i++) op(1, 0, 3'b001, 12'(i), 20'($urandom), 12'h0, 0);
        check("wr0_saturate", 32'(wr0_cnt), 32'd4096);
        for (int i = 0; i < 1026; i++) op(1, 0, 3'b011, 12'(i % 1024), 20'($urandom), 12'h0, 0);
        check("wr1_saturate", 32'(wr1_cnt), 32'd1024);
        l1_m[10'h3FF] = 20'h22222;
        op(1, 0, 3'b011, 12'h3FF, 20'h22222, 12'h0, 0);

        // End of CONV: done pulse
        cif.busy = 0;
        tick();
        check("done_pulse", 32'(done), 1);
        tick();
        check("done_clear", 32'(done), 0);

        // Readback in DONE
        rb_en = 1; rb_sel = 1; rb_addr = 12'h3FF;
        tick();
        rb_en = 0;
        check("rb_l1_3ff", 32'(rb_data), 32'h22222);
        for (int i = 0; i < 16; i++) begin
            rb_en = 1; rb_sel = 1'($urandom); rb_addr = 12'($urandom);
            exp_rb = rb_sel ? l1_m[rb_addr[9:0]] : l0_m[rb_addr];
            tick();
            rb_en = 0;
            check("rb_rand", 32'(rb_data), 32'(exp_rb));
        end
        tick();
        check("rb_hold", 32'(rb_data), 32'(exp_rb));

        // Image reload in DONE, then restart and let the handshake time out
        ld_en = 1; ld_addr = 12'd5; ld_data = 20'hF0F0F;
        tick();
        ld_en = 0;
        img_m[5] = 20'hF0F0F;
        start = 1;
        tick();
        start = 0;
        check("restart_ready", 32'(cif.ready), 1);
        check("restart_clr_err", {30'd0, hs_err, csel_err}, 0);
        check("restart_clr_cnt", {8'd0, wr0_cnt, wr1_cnt}, 0);
        n = 0;
        early_drop = 0;
        while (!hs_err && n < 200) begin
            if (!cif.ready) early_drop++;
            tick();
            n++;
        end
        check("hs_timeout_cycles", 32'(n), 32'd64);
        check("hs_ready_held", 32'(early_drop), 0);
        check("hs_ready_dropped", 32'(cif.ready), 0);
        cif.iaddr = 12'd5; #1;
        check("idle_idata_zero", 32'(cif.idata), 0);
        rb_en = 1; rb_sel = 1; rb_addr = 12'h3FF;
        tick();
        rb_en = 0;
        check("idle_rb_banks_kept", 32'(rb_data), 32'h22222);

        // Launch again; image load during handshake must be ignored
        start = 1;
        tick();
        start = 0;
        ld_en = 1; ld_addr = 12'd6; ld_data = 20'h12345;
        tick();
        ld_en = 0;
        cif.busy = 1;
        tick();
        cif.iaddr = 12'd5; #1;
        check("reload_idata5", 32'(cif.idata), 32'hF0F0F);
        cif.iaddr = 12'd6; #1;
        check("hsk_ld_ignored", 32'(cif.idata), 32'h00006);
        drive_conv(1, 0, 3'b001, 12'h010, 20'h77777, 12'h0);
        check("run2_wr0", 32'(wr0_cnt), 1);

        // Asynchronous reset in RUN
        cif.iaddr = 12'd5;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_ready", 32'(cif.ready), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_cnts", {8'd0, wr0_cnt, wr1_cnt}, 0);
        check("midrst_idle_idata", 32'(cif.idata), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global runaway guard
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
